// File: rtl/aes_encipher.sv
// Iterative AES-128/192/256 forward cipher core.
// Two cycles per round; round keys are fetched by index from an external store.
module aes_sbox_128 (
  input  logic [127:0] i_in,
  output logic [127:0] o_out
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as b^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  always_comb begin
    o_out = '0;
    for (int i = 0; i < 16; i++)
      o_out[8*i +: 8] = sbox(i_in[8*i +: 8]);
  end

endmodule

module aes_encipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   round_num,
  input  logic         plain_ready,
  input  logic [127:0] plain,
  input  logic [127:0] round_key,
  output logic [3:0]   en_round,
  output logic [127:0] cipher,
  output logic         cipher_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } fsm_t;

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic         r_phase;
  logic [3:0]   r_nr;
  logic [127:0] r_cipher;
  logic         r_ready;
  logic         r_pr;

  logic         w_start;
  logic [3:0]   w_nr;
  logic [127:0] w_sub;
  logic [127:0] w_sr;
  logic [127:0] w_mix;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
      };
    end
    return o;
  endfunction

  aes_sbox_128 u_sbox (
    .i_in  (r_state),
    .o_out (w_sub)
  );

  assign w_sr    = shift_rows(w_sub);
  assign w_mix   = mix_columns(r_state);
  assign w_start = plain_ready & ~r_pr;
  assign w_nr    = (round_num == 4'd12 ||
                    round_num == 4'd14) ?
                   round_num : 4'd10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm    <= IDLE;
      r_state  <= '0;
      r_round  <= '0;
      r_phase  <= 1'b0;
      r_nr     <= '0;
      r_cipher <= '0;
      r_ready  <= 1'b0;
      r_pr     <= 1'b1;
    end else begin
      r_pr <= plain_ready;
      unique case (r_fsm)
        IDLE: begin
          if (w_start) begin
            r_state  <= plain ^ round_key;
            r_nr     <= w_nr;
            r_round  <= 4'd1;
            r_phase  <= 1'b0;
            r_cipher <= '0;
            r_ready  <= 1'b0;
            r_fsm    <= (w_nr == 4'd1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          if (!r_phase) begin
            r_state <= w_sr;
            r_phase <= 1'b1;
          end else begin
            r_state <= w_mix ^ round_key;
            r_round <= r_round + 4'd1;
            r_phase <= 1'b0;
            if (r_round + 4'd1 == r_nr)
              r_fsm <= FINAL;
          end
        end
        FINAL: begin
          if (!r_phase) begin
            r_state <= w_sr;
            r_phase <= 1'b1;
          end else begin
            r_cipher <= r_state ^ round_key;
            r_ready  <= 1'b1;
            r_round  <= '0;
            r_state  <= '0;
            r_phase  <= 1'b0;
            r_fsm    <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign en_round     = r_round;
  assign cipher       = r_cipher;
  assign cipher_ready = r_ready;
  assign busy         = (r_fsm != IDLE);

endmodule

// File: tb/tb_aes_encipher.sv
// Scoreboard bench for aes_encipher with a byte-level AES reference model.
// Monitor checks ciphertext and completion cycle of every block.
module tb_aes_encipher;

  logic         clk;
  logic         rst_n;
  logic [3:0]   round_num;
  logic         plain_ready;
  logic [127:0] plain;
  logic [127:0] round_key;
  logic [3:0]   en_round;
  logic [127:0] cipher;
  logic         cipher_ready;
  logic         busy;

  aes_encipher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .round_num    (round_num),
    .plain_ready  (plain_ready),
    .plain        (plain),
    .round_key    (round_key),
    .en_round     (en_round),
    .cipher       (cipher),
    .cipher_ready (cipher_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    int           done;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] rk_tab [16];
  logic [7:0]   sb_tab [256];
  int           n_pass;
  int           n_total;
  int           cnt;
  bit           prev_rdy;

  assign round_key = rk_tab[en_round];

  task automatic chk(
    input string        name,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]],
            sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  task automatic expand(
    input logic [255:0] key,
    input int           nk,
    input int           nr
  );
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= nr; r++)
      rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] coef(input int d);
    return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
  endfunction

  function automatic logic [127:0] ref_enc(
    input logic [127:0] pt,
    input int           nr
  );
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   acc;
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ rk_tab[0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb_tab[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < nr) begin
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
              acc = acc ^ gm(coef((j - w + 4) % 4), s[4*c+j]);
            t[4*c+w] = acc;
          end
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++)
        s[k] = s[k] ^ rk_tab[r][127-8*k -: 8];
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    cnt = cnt + 1;
    if (rst_n) begin
      if (cipher_ready && !prev_rdy) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ready: got 1 expected 0 at %0d",
                   cnt);
        end else begin
          e = sb.pop_front();
          chk("cipher", cipher, e.ct);
          chk("latency", 128'(cnt), 128'(e.done));
        end
      end else if (sb.size() > 0 && cnt > sb[0].done) begin
        e = sb.pop_front();
        n_total++;
        $display("FAIL timeout: got none expected ready at %0d",
                 e.done);
      end
    end
    prev_rdy = cipher_ready;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic issue(
    input  logic [255:0] key,
    input  logic [3:0]   rn,
    input  logic [127:0] pt,
    input  bit           use_exp,
    input  logic [127:0] exp,
    input  bit           push,
    output int           n
  );
    int   nr;
    exp_t e;
    nr = (rn == 4'd12 || rn == 4'd14) ? int'(rn) : 10;
    if (plain_ready) begin
      plain_ready = 1'b0;
      step(1);
    end
    expand(key, nr - 6, nr);
    e.ct        = use_exp ? exp : ref_enc(pt, nr);
    round_num   = rn;
    plain       = pt;
    plain_ready = 1'b1;
    n           = cnt;
    e.done      = cnt + 2 * nr + 1;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_idle;
    step(1);
    for (int i = 0; i < 60 && busy; i++) step(1);
    chk("idle", 128'(busy), 128'(0));
    step(1);
  endtask

  localparam logic [255:0] KB =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PB =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB =
    128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PC =
    128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [7:0]   p, q, x;
    logic [255:0] kc;
    logic [255:0] kr;
    logic [127:0] pr;
    logic [3:0]   rn;
    int           n, n1, bad;
    n_pass = 0;
    n_total = 0;
    cnt = 0;
    prev_rdy = 1'b0;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2)
            ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_tab[0] = 8'h63;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    kc = '0;
    for (int i = 0; i < 32; i++) kc[255-8*i -: 8] = 8'(i);

    rst_n       = 1'b0;
    plain_ready = 1'b0;
    plain       = '0;
    round_num   = 4'd10;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_cipher", cipher, 128'h0);
    chk("rst_ready", 128'(cipher_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_en_round", 128'(en_round), 128'(0));

    // FIPS-197 B and C vectors
    issue(KB, 4'd10, PB, 1, CB, 1, n);
    wait_idle();
    issue({kc[255:128], 128'h0}, 4'd10, PC, 1,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, n);
    wait_idle();
    issue({kc[255:64], 64'h0}, 4'd12, PC, 1,
          128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1, n);
    wait_idle();
    issue(kc, 4'd14, PC, 1,
          128'h8ea2b7ca516745bfeafc49904b496089, 1, n);
    wait_idle();

    // second rising edge while busy is ignored
    issue(KB, 4'd10, PB, 1, CB, 1, n);
    step(2);
    plain_ready = 1'b0;
    step(3);
    plain_ready = 1'b1;
    plain = 128'hdeadbeef_00000000_cafef00d_12345678;
    step(1);
    chk("ign_busy", 128'(busy), 128'(1));
    chk("ign_en_round", 128'(en_round), 128'(3));
    wait_idle();

    // reset in the middle of a block
    issue(KB, 4'd10, PB, 1, CB, 0, n);
    step(9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cipher", cipher, 128'h0);
    chk("mid_rst_ready", 128'(cipher_ready), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_en_round", 128'(en_round), 128'(0));
    step(2);
    rst_n = 1'b1;
    step(30);
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_ready", 128'(cipher_ready), 128'(0));

    // illegal round_num falls back to AES-128
    issue(KB, 4'd7, PB, 1, CB, 1, n);
    bad = 0;
    for (int k = 0; k <= 20; k++) begin
      if (int'(en_round) != (k + 1) / 2) bad++;
      step(1);
    end
    chk("en_round_seq", 128'(bad), 128'(0));
    wait_idle();

    // back-to-back blocks at the minimum spacing
    issue(KB, 4'd10, PB, 1, CB, 1, n1);
    step(2);
    plain_ready = 1'b0;
    while (cnt < n1 + 21) step(1);
    issue({kc[255:128], 128'h0}, 4'd10, PC, 1,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, n);
    step(1);
    chk("b2b_ready_clr", 128'(cipher_ready), 128'(0));
    chk("b2b_cipher_clr", cipher, 128'h0);
    chk("b2b_busy", 128'(busy), 128'(1));
    wait_idle();

    // randomized blocks against the reference model
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) kr[32*i +: 32] = $urandom;
      for (int i = 0; i < 4; i++) pr[32*i +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: rn = 4'd10;
        1: rn = 4'd12;
        2: rn = 4'd14;
        default: rn = 4'($urandom_range(0, 15));
      endcase
      issue(kr, rn, pr, 0, 128'h0, 1, n);
      wait_idle();
      step($urandom_range(0, 3));
    end

    step(2);
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
